// File: rtl/csa_pkg.sv
// Shared defaults and stage-1 payload type for the pipelined carry-select adder.
// Optional subtraction mode is enabled with the CSA_SUB_EN macro.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 32;
  localparam int unsigned CSA_SPLIT = 16;
  localparam int unsigned CSA_HI_W  = CSA_WIDTH - CSA_SPLIT;

  // Stage-1 payload at the default geometry; speculative sums keep their carry in the MSB.
  typedef struct packed {
    logic [CSA_HI_W:0]    hi1;
    logic [CSA_HI_W:0]    hi0;
    logic                 lo_c;
    logic [CSA_SPLIT-1:0] lo_sum;
  } csa_s1_t;

endpackage

// File: rtl/csa_spec_slice.sv
// Upper-slice speculative adder: produces the sum for carry-in 0 and carry-in 1,
// each with its carry-out in the MSB.
module csa_spec_slice
  import csa_pkg::*;
#(
  parameter int unsigned W = CSA_HI_W
) (
  input  logic [W-1:0] a_hi,
  input  logic [W-1:0] b_hi,
  output logic [W:0]   hi0,
  output logic [W:0]   hi1
);

  localparam int unsigned SW = W + 1;

  // Both candidates are built independently so neither waits on the other.
  always_comb begin
    hi0 = SW'(a_hi) + SW'(b_hi);
    hi1 = SW'(a_hi) + SW'(b_hi) + SW'(1'b1);
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Two-stage carry-select adder with valid/ready on both sides.
// Define CSA_SUB_EN to add a 'sub' input that computes a-b (carry=1 means no borrow).
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned SPLIT = CSA_SPLIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned HI_W = WIDTH - SPLIT;
  localparam int unsigned LO_W = SPLIT + 1;

  if (SPLIT < 1 || SPLIT >= WIDTH) begin : g_bad_split
    $error("csa_pipe_adder: SPLIT must satisfy 1 <= SPLIT < WIDTH");
  end

  typedef struct packed {
    logic [HI_W:0]    hi1;
    logic [HI_W:0]    hi0;
    logic             lo_c;
    logic [SPLIT-1:0] lo_sum;
  } s1_t;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [LO_W-1:0]  lo_full;
  logic [HI_W:0]    hi0_d;
  logic [HI_W:0]    hi1_d;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             v1;
  logic             v2;
  logic             load1_c;
  logic             load2_c;

  // Subtraction inverts b and forces the carry-in, so cin is ignored in that mode.
`ifdef CSA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign lo_full = LO_W'(a[SPLIT-1:0]) + LO_W'(b_eff[SPLIT-1:0]) + LO_W'(cin_eff);

  csa_spec_slice #(
    .W (HI_W)
  ) u_spec_slice (
    .a_hi (a[WIDTH-1:SPLIT]),
    .b_hi (b_eff[WIDTH-1:SPLIT]),
    .hi0  (hi0_d),
    .hi1  (hi1_d)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.lo_sum = lo_full[SPLIT-1:0];
    s1_d.lo_c   = lo_full[SPLIT];
    s1_d.hi0    = hi0_d;
    s1_d.hi1    = hi1_d;
  end

  // Stall chain: a stage advances when it is empty or its consumer advances.
  assign load2_c  = !v2 || out_ready;
  assign load1_c  = !v1 || load2_c;
  assign in_ready = load1_c;

  // Stage 1: capture lower sum and both speculative upper sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (load1_c) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2: the registered lower carry selects the upper result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (load2_c) begin
      v2 <= v1;
      if (v1) begin
        sum   <= {(s1_q.lo_c ? s1_q.hi1[HI_W-1:0] : s1_q.hi0[HI_W-1:0]), s1_q.lo_sum};
        carry <= s1_q.lo_c ? s1_q.hi1[HI_W] : s1_q.hi0[HI_W];
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed, table-driven bench for csa_pipe_adder (default 32/16 geometry),
// with hand sequences for back-pressure and reset while results are in flight.
module tb_csa_pipe_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
`ifdef CSA_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  csa_pipe_adder #(
    .WIDTH (32),
    .SPLIT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        carry;
  } vec_t;

  vec_t tv[9];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: accepted at the next edge, visible after the one after.
  task automatic run_one(input vec_t v, input string tag);
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, sum, v.sum);
    check({tag, "_carry"}, 32'(carry), 32'(v.carry));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_in;
    int  n_out;
    bit  acc;
    bit  emit;
    vec_t v;

    tv[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tv[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tv[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    tv[5] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0};
    tv[6] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
    tv[7] = '{32'hDEADBEEF, 32'h01010101, 1'b1, 32'hDFAEBFF1, 1'b0};
    tv[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'hFFFFFFFF;
    b         = 32'h00000001;
    cin       = 1'b1;
`ifdef CSA_SUB_EN
    sub       = 1'b0;
`endif

    // Reset held with in_valid asserted must keep the outputs cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_out_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("rst%0d_sum", i), sum, 32'd0);
      check($sformatf("rst%0d_carry", i), 32'(carry), 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_one(tv[i], $sformatf("vec%0d", i));
    end

    // Four back-to-back operands with 5 cycles of downstream stall.
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 40 && n_out < 4; c++) begin
      out_ready = (c >= 5);
      in_valid  = (n_in < 4);
      if (n_in < 4) begin
        a   = tv[n_in + 3].a;
        b   = tv[n_in + 3].b;
        cin = tv[n_in + 3].cin;
      end
      #1;
      if (c == 4) begin
        check("bp_accepts_before_stall", 32'(n_in), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (out_valid) begin
        check($sformatf("bp_c%0d_sum", c), sum, tv[n_out + 3].sum);
        check($sformatf("bp_c%0d_carry", c), 32'(carry), 32'(tv[n_out + 3].carry));
        if (emit) n_out++;
      end
      step();
      if (acc) n_in++;
    end
    check("bp_results_out", 32'(n_out), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_drain%0d_no_dup", i), 32'(out_valid), 32'd0);
      step();
    end

    // Reset with two results in flight: neither may be transferred afterwards.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = tv[3].a; b = tv[3].b; cin = tv[3].cin;
    step();
    a = tv[4].a; b = tv[4].b; cin = tv[4].cin;
    step();
    in_valid = 1'b0;
    check("mid_rst_first_in_stage2", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", sum, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mid_rst_after%0d", i), 32'(out_valid), 32'd0);
    end

`ifdef CSA_SUB_EN
    sub = 1'b1;
    v = '{32'd5, 32'd7, 1'b0, 32'hFFFFFFFE, 1'b0};
    run_one(v, "sub_5m7");
    v = '{32'd7, 32'd5, 1'b0, 32'h00000002, 1'b1};
    run_one(v, "sub_7m5");
    v = '{32'd7, 32'd7, 1'b1, 32'h00000000, 1'b1};
    run_one(v, "sub_7m7_cin1");
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
